// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered 32-bit AND/OR/XOR/NOR stage feeding a 2-entry in-order result buffer.
// Build option ALU_PARITY_EN: store ^result per entry and present it on out_parity (else tied to 0).
module alu_logic_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Handshake: a transfer occurs on a rising edge where valid && ready are both high.
    // in_ready and out_valid derive from registered occupancy only, so there is no
    // combinational path from out_ready to in_ready and no same-cycle pass-through.

    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [CNT_W-1:0] op_count_q;
    logic [WIDTH-1:0] res_q [2];
    logic [1:0]       zero_q;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] result;
    logic             result_zero;

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_NOR:  result = ~(x | y);
            default: result = '0;
        endcase
    end

    assign result_zero = (result == '0);

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Accept together with pop leaves occupancy unchanged; only the pointers move.
    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                wr_ptr_q   <= ~wr_ptr_q;
                op_count_q <= op_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Entries are cleared on reset so the head reads 0 / zero=1 while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q[0] <= '0;
            res_q[1] <= '0;
            zero_q   <= 2'b11;
        end else if (accept) begin
            res_q[wr_ptr_q]  <= result;
            zero_q[wr_ptr_q] <= result_zero;
        end
    end

    assign out_result = res_q[rd_ptr_q];
    assign out_zero   = zero_q[rd_ptr_q];
    assign op_count   = op_count_q;

`ifdef ALU_PARITY_EN
    logic [1:0] par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 2'b00;
        end else if (accept) begin
            par_q[wr_ptr_q] <= ^result;
        end
    end

    assign out_parity = par_q[rd_ptr_q];
`else
    assign out_parity = 1'b0;
`endif

endmodule
